seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_if.sv | 16 +
 rtl/seq_alu.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_if.sv
// Request/response bus for seq_alu: operand/opcode request in, busy/done/result back.
interface seq_alu_if #(
    parameter int unsigned WORDSIZE = 32,
    parameter int unsigned OPSIZE   = 5
);
    logic                start;
    logic [WORDSIZE-1:0] a;
    logic [WORDSIZE-1:0] b;
    logic [OPSIZE-1:0]   op;
    logic                busy;
    logic                done;
    logic [WORDSIZE-1:0] r;

    modport master (output start, a, b, op, input busy, done, r);
    modport slave  (input start, a, b, op, output busy, done, r);
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus bit-serial multiply and
// optional restoring divide (enabled by defining SEQ_ALU_DIV_EN).
module seq_alu #(
    parameter int unsigned WORDSIZE = 32,
    parameter int unsigned OPSIZE   = 5
) (
    input  logic        clk,
    input  logic        rst,
    seq_alu_if.slave    bus
);
    localparam int unsigned W  = WORDSIZE;
    localparam int unsigned W2 = 2 * WORDSIZE;
    localparam int unsigned SW = $clog2(WORDSIZE);
    localparam int unsigned CW = $clog2(WORDSIZE + 1);

    localparam logic [OPSIZE-1:0] OP_ADD   = OPSIZE'(0);
    localparam logic [OPSIZE-1:0] OP_SUB   = OPSIZE'(1);
    localparam logic [OPSIZE-1:0] OP_SLL   = OPSIZE'(3);
    localparam logic [OPSIZE-1:0] OP_SRL   = OPSIZE'(4);
    localparam logic [OPSIZE-1:0] OP_SRA   = OPSIZE'(5);
    localparam logic [OPSIZE-1:0] OP_SLTU  = OPSIZE'(6);
    localparam logic [OPSIZE-1:0] OP_SLT   = OPSIZE'(7);
    localparam logic [OPSIZE-1:0] OP_OR    = OPSIZE'(8);
    localparam logic [OPSIZE-1:0] OP_AND   = OPSIZE'(9);
    localparam logic [OPSIZE-1:0] OP_XOR   = OPSIZE'(10);
    localparam logic [OPSIZE-1:0] OP_SHL12 = OPSIZE'(11);
    localparam logic [OPSIZE-1:0] OP_MUL   = OPSIZE'(12);
    localparam logic [OPSIZE-1:0] OP_MULH  = OPSIZE'(13);
    localparam logic [OPSIZE-1:0] OP_MULHU = OPSIZE'(14);
`ifdef SEQ_ALU_DIV_EN
    localparam logic [OPSIZE-1:0] OP_DIV   = OPSIZE'(15);
    localparam logic [OPSIZE-1:0] OP_DIVU  = OPSIZE'(16);
    localparam logic [OPSIZE-1:0] OP_REM   = OPSIZE'(17);
    localparam logic [OPSIZE-1:0] OP_REMU  = OPSIZE'(18);
`endif

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [W2-1:0]     acc, acc_n;
    logic [W-1:0]      mc, mc_n;
    logic [W-1:0]      a_q, a_n;
    logic [W-1:0]      b_q, b_n;
    logic [OPSIZE-1:0] op_q, op_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic [W-1:0]      r_q, r_n;

    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        return x[W-1] ? (W'(0) - x) : x;
    endfunction

    function automatic logic is_iter(input logic [OPSIZE-1:0] o);
        logic res;
        case (o)
            OP_MUL, OP_MULH, OP_MULHU: res = 1'b1;
`ifdef SEQ_ALU_DIV_EN
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: res = 1'b1;
`endif
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Ops that run on operand magnitudes and need sign correction in FIN.
    function automatic logic is_signed_iter(input logic [OPSIZE-1:0] o);
`ifdef SEQ_ALU_DIV_EN
        return (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM);
`else
        return (o == OP_MULH);
`endif
    endfunction

    function automatic logic [W-1:0] alu1(input logic [OPSIZE-1:0] o,
                                          input logic [W-1:0] x,
                                          input logic [W-1:0] y);
        logic [SW-1:0] sh;
        logic [W-1:0]  res;
        sh = y[SW-1:0];
        case (o)
            OP_ADD:   res = x + y;
            OP_SUB:   res = x - y;
            OP_SLL:   res = x << sh;
            OP_SRL:   res = x >> sh;
            OP_SRA:   res = W'($signed(x) >>> sh);
            OP_SLTU:  res = W'(x < y);
            OP_SLT:   res = W'($signed(x) < $signed(y));
            OP_OR:    res = x | y;
            OP_AND:   res = x & y;
            OP_XOR:   res = x ^ y;
            OP_SHL12: res = x << 12;
            default:  res = '0;
        endcase
        return res;
    endfunction

`ifdef SEQ_ALU_DIV_EN
    function automatic logic [W-1:0] neg_if(input logic n, input logic [W-1:0] x);
        return n ? (W'(0) - x) : x;
    endfunction
`endif

    function automatic logic [W-1:0] fin_result(input logic [OPSIZE-1:0] o,
                                                input logic [W2-1:0] p,
                                                input logic [W-1:0] x,
                                                input logic [W-1:0] y);
        logic [W2-1:0] ps;
        logic [W-1:0]  res;
        ps = (x[W-1] ^ y[W-1]) ? (W2'(0) - p) : p;
        case (o)
            OP_MUL:   res = p[W-1:0];
            OP_MULH:  res = W'(ps >> W);
            OP_MULHU: res = p[W2-1:W];
`ifdef SEQ_ALU_DIV_EN
            OP_DIV:   res = (y == '0) ? '1 : neg_if(x[W-1] ^ y[W-1], p[W-1:0]);
            OP_DIVU:  res = p[W-1:0];
            OP_REM:   res = (y == '0) ? x : neg_if(x[W-1], p[W2-1:W]);
            OP_REMU:  res = p[W2-1:W];
`endif
            default:  res = '0;
        endcase
        return res;
    endfunction

    // Shift-add step: acc = {partial product, remaining multiplier bits}.
    logic [W:0] mul_sum;
    assign mul_sum = {1'b0, acc[W2-1:W]} + (acc[0] ? {1'b0, mc} : (W+1)'(0));

`ifdef SEQ_ALU_DIV_EN
    // Restoring step: acc = {partial remainder, dividend/quotient}.
    logic [W:0]   div_sh;
    logic [W-1:0] div_diff;
    logic         div_ge;
    assign div_sh   = {acc[W2-1:W], acc[W-1]};
    assign div_ge   = (div_sh >= {1'b0, mc});
    assign div_diff = W'(div_sh - {1'b0, mc});
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        acc_n   = acc;
        mc_n    = mc;
        a_n     = a_q;
        b_n     = b_q;
        op_n    = op_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        r_n     = r_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (is_iter(bus.op)) begin
                        state_n = RUN;
                        busy_n  = 1'b1;
                        cnt_n   = '0;
                        a_n     = bus.a;
                        b_n     = bus.b;
                        op_n    = bus.op;
                    end else begin
                        r_n    = alu1(bus.op, bus.a, bus.b);
                        done_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    acc_n = {W'(0), is_signed_iter(op_q) ? mag(a_q) : a_q};
                    mc_n  = is_signed_iter(op_q) ? mag(b_q) : b_q;
`ifdef SEQ_ALU_DIV_EN
                end else if (op_q != OP_MUL && op_q != OP_MULH && op_q != OP_MULHU) begin
                    acc_n = div_ge ? {div_diff, acc[W-2:0], 1'b1}
                                   : {div_sh[W-1:0], acc[W-2:0], 1'b0};
`endif
                end else begin
                    acc_n = {mul_sum, acc[W-1:1]};
                end
                cnt_n = cnt + CW'(1);
                if (cnt == CW'(W)) begin
                    state_n = FIN;
                end
            end
            FIN: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                done_n  = 1'b1;
                r_n     = fin_result(op_q, acc, a_q, b_q);
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mc     <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            r_q    <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            acc    <= acc_n;
            mc     <= mc_n;
            a_q    <= a_n;
            b_q    <= b_n;
            op_q   <= op_n;
            busy_q <= busy_n;
            done_q <= done_n;
            r_q    <= r_n;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.r    = r_q;
endmodule
